// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and four-mode test-pattern generator (solid, bars, checker, moving box).
// Optional macro VGA_PATTERN_BORDER_EN adds a 1-pixel white border around the active area.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int COLOR_BITS = 2,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [1:0]            mode,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  display_en,
  output logic                  frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic [HW-1:0] BOX_MAX  = HW'(H_ACTIVE - BOX_SIZE);
  localparam logic [HW-1:0] BOX_M1   = HW'(BOX_SIZE - 1);
  localparam logic [VW-1:0] BOX_Y0   = VW'(V_ACTIVE / 2 - BOX_SIZE / 2);
  localparam logic [VW-1:0] BOX_Y1   = VW'(V_ACTIVE / 2 + BOX_SIZE / 2 - 1);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);
  localparam logic          SYNC_IDLE = !SYNC_ACT;

  logic [HW-1:0]         r_h_cnt;
  logic [VW-1:0]         r_v_cnt;
  logic [BW-1:0]         r_bar_px;
  logic [2:0]            r_bar;
  logic [HW-1:0]         r_box_x;
  logic [1:0]            r_mode_s1;
  logic [1:0]            r_mode_s2;
  logic [1:0]            r_mode;
  logic                  r_run;
  logic [COLOR_BITS-1:0] r_red;
  logic [COLOR_BITS-1:0] r_green;
  logic [COLOR_BITS-1:0] r_blue;
  logic                  r_h_sync;
  logic                  r_v_sync;
  logic                  r_de;
  logic                  r_ft;

  logic          w_at_origin;
  logic          w_h_wrap;
  logic          w_active;
  logic          w_hs_act;
  logic          w_vs_act;
  logic [1:0]    w_mode_eff;
  logic [2:0]    w_idx;
  logic [HW-1:0] w_box_end;
  logic          w_in_box;
  logic          w_check;
  logic          w_r;
  logic          w_g;
  logic          w_b;

  assign w_h_wrap    = (r_h_cnt == H_LAST);
  assign w_at_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_act    = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
  assign w_vs_act    = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
  // The first pixel of a frame is drawn with the mode being latched on that same edge.
  assign w_mode_eff  = w_at_origin ? r_mode_s2 : r_mode;
  assign w_idx       = 3'd7 - r_bar;
  assign w_box_end   = r_box_x + BOX_M1;
  assign w_in_box    = (r_h_cnt >= r_box_x) && (r_h_cnt <= w_box_end) &&
                       (r_v_cnt >= BOX_Y0) && (r_v_cnt <= BOX_Y1);
  assign w_check     = r_h_cnt[CHECK_LOG2] ^ r_v_cnt[CHECK_LOG2];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
      r_bar_px <= '0;
      r_bar    <= '0;
      r_run    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_h_wrap) begin
        r_h_cnt  <= '0;
        r_v_cnt  <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        r_bar_px <= '0;
        r_bar    <= '0;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
        if (r_bar_px == BAR_LAST) begin
          r_bar_px <= '0;
          r_bar    <= (r_bar == 3'd7) ? 3'd7 : r_bar + 3'd1;
        end else begin
          r_bar_px <= r_bar_px + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_mode_s1 <= '0;
      r_mode_s2 <= '0;
      r_mode    <= '0;
      r_box_x   <= '0;
    end else begin
      r_mode_s1 <= mode;
      r_mode_s2 <= r_mode_s1;
      if (w_at_origin) begin
        r_mode <= r_mode_s2;
        if (r_mode == 2'd3) begin
          r_box_x <= (r_box_x == BOX_MAX) ? '0 : r_box_x + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_r = 1'b0;
    w_g = 1'b0;
    w_b = 1'b0;
    case (w_mode_eff)
      2'd0: begin
        w_r = 1'b1;
        w_g = 1'b1;
        w_b = 1'b1;
      end
      2'd1: begin
        w_r = w_idx[2];
        w_g = w_idx[1];
        w_b = w_idx[0];
      end
      2'd2: begin
        w_r = w_check;
        w_g = w_check;
        w_b = w_check;
      end
      default: begin
        w_r = w_in_box;
        w_g = w_in_box;
        w_b = 1'b1;
      end
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((r_h_cnt == '0) || (r_h_cnt == H_ACT - 1'b1) ||
        (r_v_cnt == '0) || (r_v_cnt == V_ACT - 1'b1)) begin
      w_r = 1'b1;
      w_g = 1'b1;
      w_b = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_h_sync <= SYNC_IDLE;
      r_v_sync <= SYNC_IDLE;
      r_de     <= 1'b0;
      r_ft     <= 1'b0;
    end else begin
      r_red    <= w_active ? {COLOR_BITS{w_r}} : '0;
      r_green  <= w_active ? {COLOR_BITS{w_g}} : '0;
      r_blue   <= w_active ? {COLOR_BITS{w_b}} : '0;
      r_h_sync <= w_hs_act ? SYNC_ACT : SYNC_IDLE;
      r_v_sync <= w_vs_act ? SYNC_ACT : SYNC_IDLE;
      r_de     <= w_active;
      r_ft     <= w_at_origin & r_run;
    end
  end

  assign red        = r_red;
  assign green      = r_green;
  assign blue       = r_blue;
  assign h_sync     = r_h_sync;
  assign v_sync     = r_v_sync;
  assign display_en = r_de;
  assign frame_tick = r_ft;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen using a reduced 40x22 timing so whole frames fit in a short run.
// Expected pixels are pushed to a queue per clock edge and compared one cycle later against the DUT outputs.
module tb_vga_pattern_gen;

  localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 16, VFP = 1, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int CB = 2, CL = 2, BOX = 8;
  localparam int BAR_W = HA / 8;
  localparam logic [9:0] RST_VAL = 10'b0000001100;

  logic          clk_in = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CB-1:0] red, green, blue;
  logic          h_sync, v_sync, display_en, frame_tick;

  always #5 clk_in = ~clk_in;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(0), .COLOR_BITS(CB), .CHECK_LOG2(CL), .BOX_SIZE(BOX)
  ) dut (
    .clk_in(clk_in), .reset(reset), .mode(mode),
    .red(red), .green(green), .blue(blue),
    .h_sync(h_sync), .v_sync(v_sync),
    .display_en(display_en), .frame_tick(frame_tick)
  );

  typedef struct {
    int         h;
    int         v;
    int         md;
    logic [9:0] exp;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  m_h, m_v, m_mode, m_box;
  bit  m_first;

  function automatic logic [9:0] model_pixel(int h, int v, int md, int bx, bit ft);
    logic cr, cg, cb, act, hs, vs;
    int   bar, idx;
    act = (h < HA) && (v < VA);
    cr = 1'b0; cg = 1'b0; cb = 1'b0;
    case (md)
      0: begin cr = 1'b1; cg = 1'b1; cb = 1'b1; end
      1: begin
        bar = h / BAR_W;
        if (bar > 7) bar = 7;
        idx = 7 - bar;
        cr = idx[2]; cg = idx[1]; cb = idx[0];
      end
      2: begin
        cr = ((((h >> CL) ^ (v >> CL)) & 1) != 0);
        cg = cr; cb = cr;
      end
      default: begin
        cr = (h >= bx) && (h < bx + BOX) && (v >= VA / 2 - BOX / 2) && (v < VA / 2 + BOX / 2);
        cg = cr; cb = 1'b1;
      end
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
      cr = 1'b1; cg = 1'b1; cb = 1'b1;
    end
`endif
    if (!act) begin
      cr = 1'b0; cg = 1'b0; cb = 1'b0;
    end
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    return {{2{cr}}, {2{cg}}, {2{cb}}, hs, vs, act, ft};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_mode = 0; m_box = 0; m_first = 1'b1;
    sb.delete();
  endtask

  // One DUT clock edge: record the pixel for the current raster position, then advance.
  task automatic model_step();
    bit  at00;
    int  eff;
    sb_t n;
    at00 = (m_h == 0) && (m_v == 0);
    eff = at00 ? (m_first ? 0 : int'(mode)) : m_mode;
    n.h = m_h; n.v = m_v; n.md = eff;
    n.exp = model_pixel(m_h, m_v, eff, m_box, at00 && !m_first);
    sb.push_back(n);
    if (at00) begin
      if (m_mode == 3) m_box = (m_box == HA - BOX) ? 0 : m_box + 1;
      m_mode = eff;
    end
    m_first = 1'b0;
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
  endtask

  task automatic test_reset();
    sb_t        e;
    logic [9:0] got;
    #1 reset = 1'b1;
    #1;
    got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
    total++;
    if (got !== RST_VAL) begin
      bad++;
      $display("[TB] FAIL reset_async: got %b want %b", got, RST_VAL);
    end
    repeat (10) begin
      @(negedge clk_in);
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== RST_VAL) begin
        bad++;
        $display("[TB] FAIL reset_hold: got %b want %b", got, RST_VAL);
      end
    end
    reset = 1'b0;
    model_reset();
    repeat (FRAME + 20) begin
      @(posedge clk_in); model_step();
      @(negedge clk_in);
      e = sb.pop_front();
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("[TB] FAIL solid (%0d,%0d): got %b want %b", e.h, e.v, got, e.exp);
      end
    end
  endtask

  task automatic test_bars();
    sb_t        e;
    logic [9:0] got;
    logic [5:0] want;
    mode = 2'd1;
    repeat (2 * FRAME) begin
      @(posedge clk_in); model_step();
      @(negedge clk_in);
      e = sb.pop_front();
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("[TB] FAIL bars (%0d,%0d): got %b want %b", e.h, e.v, got, e.exp);
      end
      if (e.md == 1 && e.v == 1 && (e.h == 1 || e.h == BAR_W || e.h == 7 * BAR_W || e.h == HA)) begin
        want = (e.h == 1) ? 6'b111111 : (e.h == BAR_W) ? 6'b111100 : 6'b000000;
        total++;
        if (got[9:4] !== want) begin
          bad++;
          $display("[TB] FAIL bar_colour x=%0d: got %b want %b", e.h, got[9:4], want);
        end
      end
    end
  endtask

  task automatic test_checker();
    sb_t        e;
    logic [9:0] got;
    logic [5:0] want;
    mode = 2'd2;
    repeat (2 * FRAME) begin
      @(posedge clk_in); model_step();
      @(negedge clk_in);
      e = sb.pop_front();
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("[TB] FAIL checker (%0d,%0d): got %b want %b", e.h, e.v, got, e.exp);
      end
      if (e.md == 2 && ((e.h == 3 && e.v == 3) || (e.h == 4 && e.v == 1) || (e.h == 5 && e.v == 5))) begin
        want = (e.h == 4) ? 6'b111111 : 6'b000000;
        total++;
        if (got[9:4] !== want) begin
          bad++;
          $display("[TB] FAIL checker_square (%0d,%0d): got %b want %b", e.h, e.v, got[9:4], want);
        end
      end
    end
  endtask

  // Enough frames for the box to sweep right and wrap back to x=0.
  task automatic test_box();
    sb_t        e;
    logic [9:0] got;
    mode = 2'd3;
    repeat ((HA - BOX + 3) * FRAME) begin
      @(posedge clk_in); model_step();
      @(negedge clk_in);
      e = sb.pop_front();
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("[TB] FAIL box (%0d,%0d) x0=%0d: got %b want %b", e.h, e.v, m_box, got, e.exp);
      end
      if (e.md == 3 && e.h == 1 && e.v == 1) begin
        total++;
        if (got[9:4] !== 6'b000011) begin
          bad++;
          $display("[TB] FAIL box_background: got %b want %b", got[9:4], 6'b000011);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    sb_t        e;
    logic [9:0] got;
    mode = 2'd0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk_in); model_step();
      @(negedge clk_in);
      e = sb.pop_front();
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("[TB] FAIL mode_switch (%0d,%0d): got %b want %b", e.h, e.v, got, e.exp);
      end
      if (i == FRAME + 8 * HT - 1) mode = 2'd1;
    end
  endtask

  task automatic test_reset_midframe();
    sb_t        e;
    logic [9:0] got;
    int         guard;
    bit         hit;
    mode = 2'd2;
    hit = 1'b0;
    guard = 0;
    while (!hit && guard < 2 * FRAME) begin
      guard++;
      @(posedge clk_in); model_step();
      @(negedge clk_in);
      e = sb.pop_front();
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("[TB] FAIL pre_reset (%0d,%0d): got %b want %b", e.h, e.v, got, e.exp);
      end
      if (m_h == 25 && m_v == 9) hit = 1'b1;
    end
    if (!hit) begin
      total++; bad++;
      $display("[TB] FAIL reset_point: got no (25,9) want reached within %0d cycles", 2 * FRAME);
    end
    reset = 1'b1;
    #1;
    got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
    total++;
    if (got !== RST_VAL) begin
      bad++;
      $display("[TB] FAIL reset_midframe_async: got %b want %b", got, RST_VAL);
    end
    repeat (3) begin
      @(negedge clk_in);
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== RST_VAL) begin
        bad++;
        $display("[TB] FAIL reset_midframe_hold: got %b want %b", got, RST_VAL);
      end
    end
    reset = 1'b0;
    model_reset();
    repeat (FRAME + 30) begin
      @(posedge clk_in); model_step();
      @(negedge clk_in);
      e = sb.pop_front();
      got = {red, green, blue, h_sync, v_sync, display_en, frame_tick};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("[TB] FAIL post_reset (%0d,%0d): got %b want %b", e.h, e.v, got, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_checker();
    test_box();
    test_mode_switch();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation exceeded time limit");
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA timing plus test-pattern generator. Successor to the fixed-colour sync test top.
- Integrates the h/v counters and sync generation, with generic resolution, porch/sync widths, sync polarity and colour depth.
- Outputs four selectable patterns on a per-channel COLOR_BITS RGB bus.
- Sits between the pixel clock and the board VGA DAC pins; used for bring-up of new boards and monitors.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- COLOR_BITS, 2, bits per colour channel
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels
- BOX_SIZE, 32, moving-box edge length (pixels)

Ports:
- clk_in  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- mode  input  2  pattern select: 0 solid, 1 bars, 2 checker, 3 box
- red  output  COLOR_BITS  red channel
- green  output  COLOR_BITS  green channel
- blue  output  COLOR_BITS  blue channel
- h_sync  output  1  horizontal sync
- v_sync  output  1  vertical sync
- display_en  output  1  high while the output pixel is in the active area
- frame_tick  output  1  one-cycle pulse marking the first pixel of each frame

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counter widths are derived with $clog2.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap and wraps to 0 after V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- h_sync is at the active level for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. v_sync follows the same rule on v_cnt.
- All outputs are registered with exactly 1 cycle latency from the counter state, so syncs, display_en, colours and frame_tick are mutually aligned.
- frame_tick is high in the output cycle for counter state (0,0).
- Mode capture:
  - mode_reg loads from mode only when counters are at (0,0); the pattern never changes mid-frame.
  - mode may be asynchronous to the frame, so it passes through a 2-flop synchroniser first.
- Blanking: all colour outputs are 0 whenever the output pixel is outside the active area.
- Channel value: a 1-bit channel value is replicated to COLOR_BITS.
- Mode 0 (solid): all channels all-ones.
- Mode 1 (bars):
  - BAR_W = H_ACTIVE/8.
  - The bar index is produced by a sub-counter that advances every BAR_W pixels, saturates at 7 and resets at h_cnt = 0. No runtime divide.
  - idx = 7 - bar; red = idx[2], green = idx[1], blue = idx[0].
- Mode 2 (checker): white if h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2] = 1, else black.
- Mode 3 (box):
  - White square at x in [box_x, box_x+BOX_SIZE-1], y in [V_ACTIVE/2-BOX_SIZE/2, V_ACTIVE/2+BOX_SIZE/2-1]; background is blue only.
  - box_x increments by 1 at each (0,0) while mode_reg = 3.
  - After box_x = H_ACTIVE-BOX_SIZE it wraps to 0.
  - box_x holds its value in other modes.
- Reset (asynchronous, any time including mid-frame) immediately forces:
  - counters, bar counter, box_x, mode_reg and synchroniser flops to 0;
  - colours 0, display_en 0, frame_tick 0;
  - h_sync and v_sync to the inactive level (~SYNC_POL).
- First cycle after reset release:
  - counters are at (0,0), but no frame_tick is emitted for this first frame;
  - frame_tick first pulses at the wrap to the second frame;
  - mode_reg is loaded at that (0,0).

Optional Feature:
- Macro VGA_PATTERN_BORDER_EN.
- Defined: a 1-pixel white border overrides every pattern at h_cnt = 0, h_cnt = H_ACTIVE-1, v_cnt = 0 and v_cnt = V_ACTIVE-1 inside the active area. Same latency.
- Undefined: no border logic; patterns reach the edges unchanged.

Test Plan:
- Reset held 10 cycles, then released:
  - during reset: red/green/blue = 0, h_sync = v_sync = 1, display_en = 0;
  - first h_sync low on output cycle 657 after release (h_cnt 656), lasting 96 cycles;
  - h period 800, v period 420000 cycles.
- mode = 1 for a full frame: line 0 output x=0 is white (11/11/11), x=80 is yellow (11/11/00), x=560 is black, x=640..799 all 0.
- mode = 2: pixel (0,0) black, (32,0) white, (32,32) black, (31,31) black.
- mode = 3 over 3 frames: box starts at x=0, then 1, then 2 on rows 224..255. Pixel (0,240) is white in frame 1; (0,100) is blue (00/00/11).
  - Force box_x to 608: the next frame shows the box at x=0.
- mode switched 0→1 at line 200: remainder of the frame stays solid; bars appear from the next frame_tick.
- Reset asserted at h=300, v=100: outputs go to reset values within the same cycle, with no clock edge required. After release, counting restarts at (0,0).
